// File: rtl/xadc_drp_sampler.sv
// xadc_drp_sampler
//   DRP master and sample conditioner for the XADC wizard instance.
//   On each end-of-conversion a single DRP read is issued for the selected
//   auxiliary channel, the 12-bit code in do_in[15:4] is captured, and
//   2^AVG_LOG2 codes are boxcar-averaged into one output sample.
//
// Optional build macro:
//   XADC_NOISE_MASK_EN - mask each code with 12'hFF0 before accumulation.
//
// Ports:
//   sysclk       in   system clock, also the XADC DRP dclk
//   rst          in   asynchronous active-high reset
//   sel          in   raw channel-select button (asynchronous)
//   eoc_in       in   XADC end-of-conversion pulse
//   drdy_in      in   XADC DRP data ready
//   do_in[15:0]  in   XADC DRP read data, code in [15:4]
//   den_out      out  DRP enable, single-cycle pulse
//   daddr_out    out  DRP address
//   sample_out   out  averaged 12-bit code
//   sample_valid out  one-cycle strobe when sample_out updates
//   chan_out     out  channel that the accumulated data belongs to
//   timeout_err  out  sticky DRP timeout flag
//
// state | meaning
// IDLE  | waiting for eoc_in; latches channel and DRP address on exit
// REQ   | den_out is registered high for the following cycle; timer cleared
// WAIT  | waiting for drdy_in, timer counts towards TIMEOUT
// ACC   | folds the captured code into the running average
module xadc_drp_sampler #(
    parameter int         AVG_LOG2  = 4,
    parameter logic [6:0] ADDR_SEL0 = 7'h14,
    parameter logic [6:0] ADDR_SEL1 = 7'h1C,
    parameter int         TIMEOUT   = 255
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        sel,
    input  logic        eoc_in,
    input  logic        drdy_in,
    input  logic [15:0] do_in,
    output logic        den_out,
    output logic [6:0]  daddr_out,
    output logic [11:0] sample_out,
    output logic        sample_valid,
    output logic        chan_out,
    output logic        timeout_err
);

    localparam int               ACC_W    = 12 + AVG_LOG2;
    localparam int               CNT_W    = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << AVG_LOG2);
    localparam logic [7:0]       TO_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, ACC} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               sel_m;
    logic               sel_s;
    logic               cur_chan;
    logic [11:0]        code;
    logic [11:0]        code_m;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_sum;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [7:0]         to_cnt;
    logic               avg_done;
    logic               chan_change;
    logic               unused_do_lsbs;

    assign unused_do_lsbs = ^do_in[3:0];

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            sel_m <= 1'b0;
            sel_s <= 1'b0;
        end else begin
            sel_m <= sel;
            sel_s <= sel_m;
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (eoc_in) state_nxt = REQ;
            REQ:  state_nxt = WAIT;
            WAIT: begin
                // drdy wins over an expiring timer in the same cycle
                if (drdy_in)                state_nxt = ACC;
                else if (to_cnt == TO_LAST) state_nxt = IDLE;
            end
            ACC:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        code_m = code;
`ifdef XADC_NOISE_MASK_EN
        code_m = code & 12'hFF0;
`endif
        chan_change = (cur_chan != chan_out);
        // a channel change restarts the average from this code
        acc_sum = chan_change ? ACC_W'(code_m) : acc + ACC_W'(code_m);
        cnt_nxt = chan_change ? CNT_W'(1) : cnt + CNT_W'(1);
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            den_out      <= 1'b0;
            daddr_out    <= ADDR_SEL0;
            sample_out   <= 12'h000;
            sample_valid <= 1'b0;
            chan_out     <= 1'b0;
            timeout_err  <= 1'b0;
            cur_chan     <= 1'b0;
            code         <= 12'h000;
            acc          <= '0;
            cnt          <= '0;
            to_cnt       <= 8'h00;
            avg_done     <= 1'b0;
        end else begin
            den_out      <= (state == REQ);
            sample_valid <= 1'b0;
            avg_done     <= 1'b0;

            if (state == IDLE && eoc_in) begin
                cur_chan  <= sel_s;
                daddr_out <= sel_s ? ADDR_SEL1 : ADDR_SEL0;
            end

            if (state == REQ) to_cnt <= 8'h00;

            if (state == WAIT) begin
                if (drdy_in) begin
                    code <= do_in[15:4];
                end else begin
                    to_cnt <= to_cnt + 8'd1;
                    if (to_cnt == TO_LAST) timeout_err <= 1'b1;
                end
            end

            if (state == ACC) begin
                acc      <= acc_sum;
                cnt      <= cnt_nxt;
                chan_out <= cur_chan;
                avg_done <= (cnt_nxt == CNT_FULL);
            end

            // publish one cycle after the completing ACC; the FSM is in
            // IDLE/REQ here so the accumulator is never written twice
            if (avg_done) begin
                sample_out   <= 12'(acc >> AVG_LOG2);
                sample_valid <= 1'b1;
                acc          <= '0;
                cnt          <= '0;
            end
        end
    end

endmodule
